sipo_deser: RTL and testbench
=============================

// Module: sipo_deser
// PURPOSE
//   Parametrised serial-in/parallel-out deserialiser; successor to the fixed 4-bit SIPO register.
//   Shifts one bit per enabled clock, counts bits, and on every WIDTH-th bit transfers the
//   assembled word to a holding register with a valid/ready handshake and an overrun flag.
//   Sits between a serial bit source (UART/SPI-style front end) and a word-wide consumer.
// PARAMETERS
//   WIDTH      4   word length in bits; legal range >= 2
//   MSB_FIRST  1   1: first received bit ends in dout[WIDTH-1]; 0: first bit ends in dout[0]
//   CW         $clog2(WIDTH)   localparam, width of bit counter
// PORTS
//   clk        in   1       rising-edge clock
//   reset      in   1       synchronous, active-high reset
//   data_in    in   1       serial data bit, sampled when shift_en=1
//   shift_en   in   1       shift strobe; one bit accepted per clk with shift_en=1
//   clear      in   1       sync soft clear of partial word (shift reg + counter only)
//   q          out  WIDTH   live shift-register contents (partial word)
//   bit_cnt    out  CW      bits received in current word, 0..WIDTH-1
//   dout       out  WIDTH   last completed word
//   dout_valid out  1       dout holds an unconsumed word
//   dout_ready in   1       consumer accepts dout when dout_valid=1
//   overrun    out  1       sticky: a completed word overwrote an unconsumed one
// BEHAVIOUR
//   - Reset (reset=1 at edge): q=0, bit_cnt=0, dout=0, dout_valid=0, overrun=0; all other inputs ignored.
//   - Priority per edge: reset > clear > shift_en. Handshake logic evaluated independently of clear.
//   - Shift (shift_en=1, clear=0): MSB_FIRST=1: q <= {q[WIDTH-2:0], data_in};
//     MSB_FIRST=0: q <= {data_in, q[WIDTH-1:1]}. bit_cnt <= bit_cnt+1.
//   - Word completion: shift with bit_cnt==WIDTH-1 -> dout <= shifted value (incl. this bit),
//     dout_valid <= 1, bit_cnt <= 0; q takes shifted value (not zeroed). Latency: dout_valid
//     high in cycle after the edge sampling the last bit.
//   - shift_en=0: q, bit_cnt hold. No bit lost or duplicated across gaps of any length.
//   - clear=1: q <= 0, bit_cnt <= 0; dout, dout_valid, overrun untouched; any shift that cycle discarded.
//   - Handshake: dout_valid & dout_ready at edge -> word consumed, dout_valid <= 0, unless a
//     completion occurs same edge -> dout_valid stays 1, dout = new word, overrun unchanged.
//   - dout stable while dout_valid=1 and no new completion.
//   - Completion while dout_valid=1 & dout_ready=0 -> dout overwritten with new word,
//     dout_valid stays 1, overrun <= 1. overrun clears only on reset.
//   - dout_ready while dout_valid=0: no effect.
//   - Reset mid-word: partial word discarded; next bit after reset is bit 0 of a new word.
// TESTING (WIDTH=4 unless stated)
//   1 reset=1 2 clks with data_in=1, shift_en=1 -> q=0, bit_cnt=0, dout_valid=0, overrun=0.
//   2 MSB_FIRST=1, shift 1,0,1,1 consecutive, dout_ready=1 -> dout=4'b1011, dout_valid 1 cycle
//     after 4th edge, deasserts next edge; bit_cnt 1,2,3,0.
//   3 MSB_FIRST=0, same bits with shift_en gaps of 0..3 cycles -> dout=4'b1101, single valid.
//   4 dout_ready=0, send 1010 then 0110 -> after 2nd word dout=4'b0110, dout_valid=1, overrun=1;
//     then dout_ready=1 one cycle -> dout_valid=0, overrun stays 1.
//   5 Shift 3 bits, assert clear with shift_en=1 -> bit_cnt=0, q=0; next 4 bits 0011 -> dout=4'b0011;
//     earlier pending dout/dout_valid unaffected by clear.
//   6 WIDTH=8: dout_ready pulsed on same edge as next word completes -> dout_valid stays 1,
//     dout=new byte, overrun=0; then reset mid-word -> subsequent 8 bits form clean word.

Source files
------------

// File: rtl/sipo_deser.sv
// ----------------------------------------------------------------------------
// sipo_deser
//   Parametrised serial-in / parallel-out deserialiser. One serial bit is
//   accepted on each clock with shift_en high. A counter tracks how many bits
//   of the current word have arrived. On the WIDTH-th bit the assembled word
//   is copied into a holding register. The holding register is offered to a
//   word-wide consumer through a valid/ready handshake. A sticky overrun flag
//   records any completed word that overwrote one the consumer had not taken.
//
// Parameters
//   WIDTH      word length in bits, must be >= 2
//   MSB_FIRST  1: first received bit lands in dout[WIDTH-1]
//              0: first received bit lands in dout[0]
//
// Ports
//   clk         in   1      rising-edge clock
//   reset       in   1      synchronous active-high reset
//   data_in     in   1      serial data bit, sampled when shift_en=1
//   shift_en    in   1      shift strobe, one bit per enabled clock
//   clear       in   1      soft clear of the partial word (q, bit_cnt)
//   q           out  WIDTH  live shift-register contents
//   bit_cnt     out  CW     bits received in the current word
//   dout        out  WIDTH  last completed word
//   dout_valid  out  1      dout holds a word not yet consumed
//   dout_ready  in   1      consumer accepts dout while dout_valid=1
//   overrun     out  1      sticky: a completed word replaced an unconsumed one
// ----------------------------------------------------------------------------
module sipo_deser #(
    parameter int WIDTH     = 4,
    parameter bit MSB_FIRST = 1'b1,
    localparam int CW       = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             data_in,
    input  logic             shift_en,
    input  logic             clear,
    output logic [WIDTH-1:0] q,
    output logic [CW-1:0]    bit_cnt,
    output logic [WIDTH-1:0] dout,
    output logic             dout_valid,
    input  logic             dout_ready,
    output logic             overrun
);

    // Counter value held while the last bit of a word is being received.
    localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

    logic [WIDTH-1:0] r_q;
    logic [CW-1:0]    r_bitCnt;
    logic [WIDTH-1:0] r_dout;
    logic             r_doutValid;
    logic             r_overrun;

    logic [WIDTH-1:0] w_shifted;
    logic             w_shiftAcc;
    logic             w_complete;
    logic             w_consume;

    // Next shift-register value if a bit is accepted this cycle. The bit
    // order decides which end the new bit enters from, so that the first bit
    // of a word ends at the requested end of dout once the word is complete.
    generate
        if (MSB_FIRST) begin : g_msbFirst
            assign w_shifted = {r_q[WIDTH-2:0], data_in};
        end else begin : g_lsbFirst
            assign w_shifted = {data_in, r_q[WIDTH-1:1]};
        end
    endgenerate

    // A clear cancels any shift in the same cycle. A word completes when
    // the accepted bit is the last one of the word. The consumer only takes
    // a word that is actually being presented.
    always_comb begin
        w_shiftAcc = shift_en & ~clear;
        w_complete = w_shiftAcc & (r_bitCnt == LAST_IDX);
        w_consume  = r_doutValid & dout_ready;
    end

    // Partial-word path: shift register and bit counter. On completion the
    // shift register keeps the shifted value rather than zeroing, because
    // every bit of the next word will overwrite it before it is used.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_q      <= '0;
            r_bitCnt <= '0;
        end else if (clear) begin
            r_q      <= '0;
            r_bitCnt <= '0;
        end else if (shift_en) begin
            r_q <= w_shifted;
            if (w_complete) begin
                r_bitCnt <= '0;
            end else begin
                r_bitCnt <= r_bitCnt + CW'(1);
            end
        end
    end

    // Holding register and handshake. This path does not look at clear, so a
    // pending word survives a soft clear. A completion takes priority over a
    // consume on the same edge: the new word replaces the consumed one and
    // valid stays high. The new word counts as an overrun only when the old
    // word was still pending and the consumer was not taking it.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_dout      <= '0;
            r_doutValid <= 1'b0;
            r_overrun   <= 1'b0;
        end else if (w_complete) begin
            r_dout      <= w_shifted;
            r_doutValid <= 1'b1;
            if (r_doutValid && !dout_ready) begin
                r_overrun <= 1'b1;
            end
        end else if (w_consume) begin
            r_doutValid <= 1'b0;
        end
    end

    assign q          = r_q;
    assign bit_cnt    = r_bitCnt;
    assign dout       = r_dout;
    assign dout_valid = r_doutValid;
    assign overrun    = r_overrun;

endmodule

// File: tb/tb_sipo_deser.sv
// ----------------------------------------------------------------------------
// tb_sipo_deser
//   Exercises three deserialisers that share a clock and a reset:
//     dut0  WIDTH=4, MSB first
//     dut1  WIDTH=4, LSB first
//     dut8  WIDTH=8, MSB first
//   Expected words come from a bit-placement model. Each word is pushed to a
//   queue when its bits are driven and popped when the word appears on dout.
// ----------------------------------------------------------------------------
module tb_sipo_deser;

    logic clk = 1'b0;
    logic reset;

    // Inputs for the two 4-bit instances, indexed by instance number.
    logic [1:0] din, sen, clr, rdy;
    logic [3:0] q0, q1, dout0, dout1;
    logic [1:0] cnt0, cnt1;
    logic       v0, v1, ov0, ov1;

    // The 8-bit instance.
    logic       din8, sen8, clr8, rdy8;
    logic [7:0] q8, dout8;
    logic [2:0] cnt8;
    logic       v8, ov8;

    int checks   = 0;
    int failures = 0;

    logic [7:0] sb[$];
    logic [7:0] expWord;

    sipo_deser #(.WIDTH(4), .MSB_FIRST(1'b1)) dut0 (
        .clk(clk), .reset(reset), .data_in(din[0]), .shift_en(sen[0]),
        .clear(clr[0]), .q(q0), .bit_cnt(cnt0), .dout(dout0),
        .dout_valid(v0), .dout_ready(rdy[0]), .overrun(ov0)
    );

    sipo_deser #(.WIDTH(4), .MSB_FIRST(1'b0)) dut1 (
        .clk(clk), .reset(reset), .data_in(din[1]), .shift_en(sen[1]),
        .clear(clr[1]), .q(q1), .bit_cnt(cnt1), .dout(dout1),
        .dout_valid(v1), .dout_ready(rdy[1]), .overrun(ov1)
    );

    sipo_deser #(.WIDTH(8), .MSB_FIRST(1'b1)) dut8 (
        .clk(clk), .reset(reset), .data_in(din8), .shift_en(sen8),
        .clear(clr8), .q(q8), .bit_cnt(cnt8), .dout(dout8),
        .dout_valid(v8), .dout_ready(rdy8), .overrun(ov8)
    );

    always #5 clk = ~clk;

    // Hard time limit so the run always ends.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation still running at time %0t, required completion", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    // Advance one clock and sample 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Bit i of the sequence is seq[W-1-i], so the word reads left to right
    // in arrival order. MSB first puts arrival i at position W-1-i;
    // LSB first puts it at position i.
    function automatic logic [3:0] model4(input logic msbFirst, input logic [3:0] seq);
        logic [3:0] res;
        res = '0;
        for (int i = 0; i < 4; i++) begin
            if (msbFirst) res[3 - i] = seq[3 - i];
            else          res[i]     = seq[3 - i];
        end
        return res;
    endfunction

    function automatic logic [7:0] model8(input logic [7:0] seq);
        logic [7:0] res;
        res = '0;
        for (int i = 0; i < 8; i++) res[7 - i] = seq[7 - i];
        return res;
    endfunction

    // Push the expected word, then drive its 4 bits back to back.
    task automatic sendWord4(input int d, input logic [3:0] seq);
        sb.push_back({4'b0, model4(d == 0, seq)});
        for (int i = 0; i < 4; i++) begin
            din[d] = seq[3 - i];
            sen[d] = 1'b1;
            tick();
        end
        sen[d] = 1'b0;
    endtask

    task automatic popExpected();
        if (sb.size() == 0) begin
            failures++;
            $display("[TB] FAIL scoreboard_empty: got 0 entries, required at least 1");
            expWord = 8'hxx;
        end else begin
            expWord = sb.pop_front();
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        din = 2'b11; sen = 2'b11; clr = 2'b00; rdy = 2'b11;
        din8 = 1'b1; sen8 = 1'b1; clr8 = 1'b0; rdy8 = 1'b1;
        tick();
        tick();
        checks++;
        if ({q0, cnt0, dout0, v0, ov0} !== 12'b0) begin
            failures++;
            $display("[TB] FAIL reset_dut0: got q=%b cnt=%0d dout=%b v=%b ov=%b, required all zero", q0, cnt0, dout0, v0, ov0);
        end
        checks++;
        if ({q1, cnt1, dout1, v1, ov1} !== 12'b0) begin
            failures++;
            $display("[TB] FAIL reset_dut1: got q=%b cnt=%0d dout=%b v=%b ov=%b, required all zero", q1, cnt1, dout1, v1, ov1);
        end
        checks++;
        if ({q8, cnt8, dout8, v8, ov8} !== 21'b0) begin
            failures++;
            $display("[TB] FAIL reset_dut8: got q=%h cnt=%0d dout=%h v=%b ov=%b, required all zero", q8, cnt8, dout8, v8, ov8);
        end
        reset = 1'b0;
        din = 2'b00; sen = 2'b00; rdy = 2'b00;
        din8 = 1'b0; sen8 = 1'b0; rdy8 = 1'b0;
    endtask

    task automatic test_msb_first();
        logic [3:0] seq;
        seq = 4'b1011;
        rdy[0] = 1'b1;
        sb.push_back({4'b0, model4(1'b1, seq)});
        for (int i = 0; i < 4; i++) begin
            din[0] = seq[3 - i];
            sen[0] = 1'b1;
            tick();
            checks++;
            if (cnt0 !== 2'((i + 1) % 4)) begin
                failures++;
                $display("[TB] FAIL msb_bit_cnt[%0d]: got %0d, required %0d", i, cnt0, (i + 1) % 4);
            end
            checks++;
            if (v0 !== (i == 3)) begin
                failures++;
                $display("[TB] FAIL msb_valid[%0d]: got %b, required %b", i, v0, (i == 3));
            end
        end
        sen[0] = 1'b0;
        popExpected();
        checks++;
        if (dout0 !== expWord[3:0]) begin
            failures++;
            $display("[TB] FAIL msb_dout: got %b, required %b", dout0, expWord[3:0]);
        end
        checks++;
        if (q0 !== 4'b1011) begin
            failures++;
            $display("[TB] FAIL msb_q_after_word: got %b, required 1011", q0);
        end
        tick();
        checks++;
        if (v0 !== 1'b0) begin
            failures++;
            $display("[TB] FAIL msb_valid_drop: got %b, required 0", v0);
        end
        rdy[0] = 1'b0;
    endtask

    task automatic test_lsb_first_gaps();
        logic [3:0] seq;
        int         pulses;
        seq = 4'b1011;
        rdy[1] = 1'b1;
        sb.push_back({4'b0, model4(1'b0, seq)});
        for (int i = 0; i < 4; i++) begin
            for (int g = 0; g < i; g++) begin
                sen[1] = 1'b0;
                din[1] = ~seq[3 - i];
                tick();
                checks++;
                if (cnt1 !== 2'(i) || v1 !== 1'b0) begin
                    failures++;
                    $display("[TB] FAIL lsb_gap_hold[%0d.%0d]: got cnt=%0d v=%b, required cnt=%0d v=0", i, g, cnt1, v1, i);
                end
            end
            din[1] = seq[3 - i];
            sen[1] = 1'b1;
            tick();
        end
        sen[1] = 1'b0;
        popExpected();
        checks++;
        if (v1 !== 1'b1 || dout1 !== expWord[3:0]) begin
            failures++;
            $display("[TB] FAIL lsb_dout: got v=%b dout=%b, required v=1 dout=%b", v1, dout1, expWord[3:0]);
        end
        pulses = 0;
        for (int k = 0; k < 3; k++) begin
            tick();
            if (v1) pulses++;
        end
        checks++;
        if (pulses !== 0) begin
            failures++;
            $display("[TB] FAIL lsb_single_valid: got %0d extra valid cycles, required 0", pulses);
        end
        rdy[1] = 1'b0;
    endtask

    task automatic test_overrun();
        rdy[0] = 1'b0;
        sendWord4(0, 4'b1010);
        popExpected();
        checks++;
        if (v0 !== 1'b1 || dout0 !== expWord[3:0] || ov0 !== 1'b0) begin
            failures++;
            $display("[TB] FAIL ovr_first: got v=%b dout=%b ov=%b, required v=1 dout=%b ov=0", v0, dout0, ov0, expWord[3:0]);
        end
        sendWord4(0, 4'b0110);
        popExpected();
        checks++;
        if (v0 !== 1'b1 || dout0 !== expWord[3:0] || ov0 !== 1'b1) begin
            failures++;
            $display("[TB] FAIL ovr_second: got v=%b dout=%b ov=%b, required v=1 dout=%b ov=1", v0, dout0, ov0, expWord[3:0]);
        end
        rdy[0] = 1'b1;
        tick();
        rdy[0] = 1'b0;
        checks++;
        if (v0 !== 1'b0 || ov0 !== 1'b1) begin
            failures++;
            $display("[TB] FAIL ovr_consume: got v=%b ov=%b, required v=0 ov=1", v0, ov0);
        end
    endtask

    task automatic test_clear();
        rdy[0] = 1'b0;
        sendWord4(0, 4'b1100);
        popExpected();
        checks++;
        if (v0 !== 1'b1 || dout0 !== expWord[3:0]) begin
            failures++;
            $display("[TB] FAIL clr_pending: got v=%b dout=%b, required v=1 dout=%b", v0, dout0, expWord[3:0]);
        end
        for (int i = 0; i < 3; i++) begin
            din[0] = 1'b1;
            sen[0] = 1'b1;
            tick();
        end
        checks++;
        if (cnt0 !== 2'd3) begin
            failures++;
            $display("[TB] FAIL clr_partial_cnt: got %0d, required 3", cnt0);
        end
        clr[0] = 1'b1;
        tick();
        clr[0] = 1'b0;
        sen[0] = 1'b0;
        checks++;
        if (cnt0 !== 2'd0 || q0 !== 4'b0000) begin
            failures++;
            $display("[TB] FAIL clr_partial: got cnt=%0d q=%b, required cnt=0 q=0000", cnt0, q0);
        end
        checks++;
        if (v0 !== 1'b1 || dout0 !== 4'b1100 || ov0 !== 1'b1) begin
            failures++;
            $display("[TB] FAIL clr_keeps_dout: got v=%b dout=%b ov=%b, required v=1 dout=1100 ov=1", v0, dout0, ov0);
        end
        rdy[0] = 1'b1;
        tick();
        sendWord4(0, 4'b0011);
        popExpected();
        checks++;
        if (v0 !== 1'b1 || dout0 !== expWord[3:0]) begin
            failures++;
            $display("[TB] FAIL clr_next_word: got v=%b dout=%b, required v=1 dout=%b", v0, dout0, expWord[3:0]);
        end
        tick();
        rdy[0] = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [7:0] seq;
        rdy8 = 1'b0;
        seq = 8'hA5;
        sb.push_back(model8(seq));
        for (int i = 0; i < 8; i++) begin
            din8 = seq[7 - i]; sen8 = 1'b1; tick();
        end
        sen8 = 1'b0;
        popExpected();
        checks++;
        if (v8 !== 1'b1 || dout8 !== expWord || ov8 !== 1'b0) begin
            failures++;
            $display("[TB] FAIL b2b_first: got v=%b dout=%h ov=%b, required v=1 dout=%h ov=0", v8, dout8, ov8, expWord);
        end
        seq = 8'h3C;
        sb.push_back(model8(seq));
        for (int i = 0; i < 7; i++) begin
            din8 = seq[7 - i]; sen8 = 1'b1; tick();
        end
        checks++;
        if (v8 !== 1'b1 || dout8 !== 8'hA5 || cnt8 !== 3'd7) begin
            failures++;
            $display("[TB] FAIL b2b_stable: got v=%b dout=%h cnt=%0d, required v=1 dout=a5 cnt=7", v8, dout8, cnt8);
        end
        din8 = seq[0]; rdy8 = 1'b1; tick();
        rdy8 = 1'b0; sen8 = 1'b0;
        popExpected();
        checks++;
        if (v8 !== 1'b1 || dout8 !== expWord || ov8 !== 1'b0) begin
            failures++;
            $display("[TB] FAIL b2b_same_edge: got v=%b dout=%h ov=%b, required v=1 dout=%h ov=0", v8, dout8, ov8, expWord);
        end
        rdy8 = 1'b1; tick(); rdy8 = 1'b0;
        checks++;
        if (v8 !== 1'b0) begin
            failures++;
            $display("[TB] FAIL b2b_consume: got v=%b, required 0", v8);
        end
        for (int i = 0; i < 3; i++) begin
            din8 = 1'b1; sen8 = 1'b1; tick();
        end
        reset = 1'b1; tick(); reset = 1'b0;
        checks++;
        if (cnt8 !== 3'd0 || q8 !== 8'h00 || v8 !== 1'b0 || ov8 !== 1'b0) begin
            failures++;
            $display("[TB] FAIL b2b_mid_reset: got cnt=%0d q=%h v=%b ov=%b, required all zero", cnt8, q8, v8, ov8);
        end
        seq = 8'h96;
        rdy8 = 1'b1;
        sb.push_back(model8(seq));
        for (int i = 0; i < 8; i++) begin
            din8 = seq[7 - i]; sen8 = 1'b1; tick();
        end
        sen8 = 1'b0;
        popExpected();
        checks++;
        if (v8 !== 1'b1 || dout8 !== expWord || ov8 !== 1'b0) begin
            failures++;
            $display("[TB] FAIL b2b_after_reset: got v=%b dout=%h ov=%b, required v=1 dout=%h ov=0", v8, dout8, ov8, expWord);
        end
        tick();
        rdy8 = 1'b0;
    endtask

    initial begin
        $display("[TB] starting sipo_deser bench");
        test_reset();
        test_msb_first();
        test_lsb_first_gaps();
        test_overrun();
        test_clear();
        test_back_to_back();
        checks++;
        if (sb.size() !== 0) begin
            failures++;
            $display("[TB] FAIL scoreboard_drain: got %0d leftover entries, required 0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
